// File: rtl/dccm_arbiter_pkg.sv
// rtl/dccm_arbiter_pkg.sv - shared types, default parameters and helpers for the DCCM arbiter
package dccm_arbiter_pkg;

    // Owner tag carried alongside each in-flight DCCM read.
    typedef enum logic {
        OWN_LSU = 1'b0,
        OWN_EXT = 1'b1
    } dccm_owner_e;

    // Default build configuration.
    localparam int DEFAULT_XLEN         = 32;
    localparam int DEFAULT_RD_LAT       = 1;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    // Width of a starvation counter able to hold 0..limit; never narrower than one bit.
    function automatic int ctr_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dccm_arbiter_if.sv
// rtl/dccm_arbiter_if.sv - LSU, external requester and DCCM port bundle for the arbiter
interface dccm_arbiter_if #(
    parameter int XLEN = 32
) ();

    // LSU read/write request and read return
    logic [XLEN-1:0] lsu_raddr;
    logic            lsu_rvalid_in;
    logic [XLEN-1:0] lsu_rdata;
    logic            lsu_rvalid_out;
    logic [XLEN-1:0] lsu_waddr;
    logic            lsu_wen;
    logic [XLEN-1:0] lsu_wdata;
    logic            lsu_stall;

    // External requester (loader / debug DMA)
    logic            ext_req;
    logic            ext_we;
    logic [XLEN-1:0] ext_addr;
    logic [XLEN-1:0] ext_wdata;
    logic            ext_gnt;
    logic [XLEN-1:0] ext_rdata;
    logic            ext_rvalid;

    // DCCM read and write ports
    logic [XLEN-1:0] mem_raddr;
    logic            mem_rvalid_in;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid_out;
    logic [XLEN-1:0] mem_waddr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;

    // Arbiter side
    modport slave (
        input  lsu_raddr, lsu_rvalid_in, lsu_waddr, lsu_wen, lsu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata, mem_rvalid_out,
        output lsu_rdata, lsu_rvalid_out, lsu_stall,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_raddr, mem_rvalid_in, mem_waddr, mem_wen, mem_wdata
    );

    // Requesters plus DCCM side
    modport master (
        output lsu_raddr, lsu_rvalid_in, lsu_waddr, lsu_wen, lsu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata, mem_rvalid_out,
        input  lsu_rdata, lsu_rvalid_out, lsu_stall,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_raddr, mem_rvalid_in, mem_waddr, mem_wen, mem_wdata
    );

endinterface

// File: rtl/dccm_arbiter_starve_ctr.sv
// rtl/dccm_arbiter_starve_ctr.sv - saturating per-port starvation counter with limit flag
module dccm_starve_ctr
    import dccm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_req,
    input  logic ext_gnt,
    output logic limit_hit
);

    localparam int            W     = ctr_width(STARVE_LIMIT);
    localparam logic [W-1:0]  LIMIT = W'(STARVE_LIMIT);

    logic [W-1:0] count;

    // Count consecutive denials; a grant clears, idle holds, the limit saturates.
    // With a limit of 0 the counter can never leave 0, so protection is off.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ext_req && ext_gnt) begin
            count <= '0;
        end else if (ext_req && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // The external requester is owed this port once the limit has been reached.
    always_comb begin
        limit_hit = (STARVE_LIMIT != 0) && (count == LIMIT);
    end

endmodule

// File: rtl/dccm_arbiter.sv
// rtl/dccm_arbiter.sv - LSU-priority DCCM arbiter with starvation guard and owner-tagged read return
module dccm_arbiter
    import dccm_arbiter_pkg::*;
#(
    parameter int XLEN         = DEFAULT_XLEN,
    parameter int RD_LAT       = DEFAULT_RD_LAT,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           rst,
    dccm_arbiter_if.slave  bus
);

    localparam logic [XLEN-1:0] ZERO = '0;

    logic lsu_rd;
    logic ext_rd;
    logic lsu_wr;
    logic ext_wr;

    logic rd_limit_hit;
    logic wr_limit_hit;

    logic rd_ext_gnt;
    logic rd_lsu_gnt;
    logic rd_override;
    logic wr_ext_gnt;
    logic wr_lsu_gnt;
    logic wr_override;

    logic [RD_LAT-1:0] stg_valid;
    dccm_owner_e       stg_owner [RD_LAT];
    logic              resp;

    // Classify requests per port: external reads touch only the read port, writes only the write port.
    always_comb begin
        lsu_rd = bus.lsu_rvalid_in;
        lsu_wr = bus.lsu_wen;
        ext_rd = bus.ext_req & ~bus.ext_we;
        ext_wr = bus.ext_req &  bus.ext_we;
    end

    dccm_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_rd_ctr (
        .clk       (clk),
        .rst       (rst),
        .ext_req   (ext_rd),
        .ext_gnt   (rd_ext_gnt),
        .limit_hit (rd_limit_hit)
    );

    dccm_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wr_ctr (
        .clk       (clk),
        .rst       (rst),
        .ext_req   (ext_wr),
        .ext_gnt   (wr_ext_gnt),
        .limit_hit (wr_limit_hit)
    );

    // Per-port grant: LSU first unless the external side has hit its starvation limit.
    always_comb begin
        rd_ext_gnt  = ext_rd & (~lsu_rd | rd_limit_hit);
        rd_override = lsu_rd & rd_ext_gnt;
        rd_lsu_gnt  = lsu_rd & ~rd_override;

        wr_ext_gnt  = ext_wr & (~lsu_wr | wr_limit_hit);
        wr_override = lsu_wr & wr_ext_gnt;
        wr_lsu_gnt  = lsu_wr & ~wr_override;

        bus.ext_gnt   = rd_ext_gnt | wr_ext_gnt;
        bus.lsu_stall = rd_override | wr_override;
    end

    // Steer the granted requester onto the DCCM ports; idle ports drive zeros.
    always_comb begin
        bus.mem_raddr     = ZERO;
        bus.mem_rvalid_in = 1'b0;
        bus.mem_waddr     = ZERO;
        bus.mem_wdata     = ZERO;
        bus.mem_wen       = 1'b0;

        if (rd_ext_gnt) begin
            bus.mem_raddr     = bus.ext_addr;
            bus.mem_rvalid_in = 1'b1;
        end else if (rd_lsu_gnt) begin
            bus.mem_raddr     = bus.lsu_raddr;
            bus.mem_rvalid_in = 1'b1;
        end

        if (wr_ext_gnt) begin
            bus.mem_waddr = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
            bus.mem_wen   = 1'b1;
        end else if (wr_lsu_gnt) begin
            bus.mem_waddr = bus.lsu_waddr;
            bus.mem_wdata = bus.lsu_wdata;
            bus.mem_wen   = 1'b1;
        end
    end

    // Owner shift register matched to the DCCM read latency; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                stg_owner[i] <= OWN_LSU;
            end
        end else begin
            stg_valid[0] <= bus.mem_rvalid_in;
            stg_owner[0] <= rd_ext_gnt ? OWN_EXT : OWN_LSU;
            for (int i = 1; i < RD_LAT; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_owner[i] <= stg_owner[i-1];
            end
        end
    end

    // Route returning data to its owner; untracked returns and anything seen during reset are dropped.
    always_comb begin
        resp               = bus.mem_rvalid_out & stg_valid[RD_LAT-1] & ~rst;
        bus.lsu_rvalid_out = resp & (stg_owner[RD_LAT-1] == OWN_LSU);
        bus.ext_rvalid     = resp & (stg_owner[RD_LAT-1] == OWN_EXT);
        bus.lsu_rdata      = bus.lsu_rvalid_out ? bus.mem_rdata : ZERO;
        bus.ext_rdata      = bus.ext_rvalid     ? bus.mem_rdata : ZERO;
    end

endmodule

// File: tb/tb_dccm_arbiter.sv
// tb/tb_dccm_arbiter.sv - directed self-checking bench for dccm_arbiter
module tb_dccm_arbiter;

    localparam int XLEN   = 32;
    localparam int RD_LAT = 2;
    localparam int SLIM   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    dccm_arbiter_if #(.XLEN(XLEN)) bus ();

    dccm_arbiter #(
        .XLEN         (XLEN),
        .RD_LAT       (RD_LAT),
        .STARVE_LIMIT (SLIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // DCCM model: word array, read sampled before the same-edge write, RD_LAT=2 return pipe, no reset.
    logic [31:0] dccm [0:255];
    logic [1:0]  m_rv = 2'b00;
    logic [31:0] m_rd0 = '0;
    logic [31:0] m_rd1 = '0;
    logic [31:0] rdv;

    always @(posedge clk) begin
        rdv = dccm[bus.mem_raddr[9:2]];
        if (bus.mem_wen) dccm[bus.mem_waddr[9:2]] = bus.mem_wdata;
        m_rv  <= {m_rv[0], bus.mem_rvalid_in};
        m_rd0 <= rdv;
        m_rd1 <= m_rd0;
    end

    assign bus.mem_rvalid_out = m_rv[1];
    assign bus.mem_rdata      = m_rd1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.lsu_raddr     = '0;
        bus.lsu_rvalid_in = 1'b0;
        bus.lsu_waddr     = '0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = '0;
        bus.ext_req       = 1'b0;
        bus.ext_we        = 1'b0;
        bus.ext_addr      = '0;
        bus.ext_wdata     = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b0) begin failures++; $display("FAIL rst_lsu_rvalid got=%b exp=0", bus.lsu_rvalid_out); end
        checks++; if (bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL rst_ext_rvalid got=%b exp=0", bus.ext_rvalid); end
        checks++; if (bus.lsu_rdata !== 32'h0) begin failures++; $display("FAIL rst_lsu_rdata got=%h exp=0", bus.lsu_rdata); end
        checks++; if (bus.ext_rdata !== 32'h0) begin failures++; $display("FAIL rst_ext_rdata got=%h exp=0", bus.ext_rdata); end
        checks++; if ({bus.ext_gnt, bus.lsu_stall, bus.mem_wen, bus.mem_rvalid_in} !== 4'b0) begin failures++; $display("FAIL rst_idle_ctl got=%b exp=0000", {bus.ext_gnt, bus.lsu_stall, bus.mem_wen, bus.mem_rvalid_in}); end
        checks++; if ({bus.mem_raddr, bus.mem_waddr, bus.mem_wdata} !== 96'h0) begin failures++; $display("FAIL rst_idle_bus got=%h exp=0", {bus.mem_raddr, bus.mem_waddr, bus.mem_wdata}); end
        next_cycle();
    endtask

    task automatic test_lsu_read();
        bus.lsu_rvalid_in = 1'b1;
        bus.lsu_raddr     = 32'h10;
        @(negedge clk);
        checks++; if (bus.mem_rvalid_in !== 1'b1 || bus.mem_raddr !== 32'h10) begin failures++; $display("FAIL lsu_rd_issue got=%b/%h exp=1/00000010", bus.mem_rvalid_in, bus.mem_raddr); end
        checks++; if (bus.ext_gnt !== 1'b0 || bus.lsu_stall !== 1'b0) begin failures++; $display("FAIL lsu_rd_gnt got=%b%b exp=00", bus.ext_gnt, bus.lsu_stall); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b0) begin failures++; $display("FAIL lsu_rd_early got=%b exp=0", bus.lsu_rvalid_out); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b1 || bus.lsu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lsu_rd_data got=%b/%h exp=1/deadbeef", bus.lsu_rvalid_out, bus.lsu_rdata); end
        checks++; if (bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL lsu_rd_ext_quiet got=%b exp=0", bus.ext_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b0) begin failures++; $display("FAIL lsu_rd_dup got=%b exp=0", bus.lsu_rvalid_out); end
        next_cycle();
    endtask

    task automatic test_ext_write();
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b1;
        bus.ext_addr  = 32'h20;
        bus.ext_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (bus.ext_gnt !== 1'b1) begin failures++; $display("FAIL ext_wr_gnt got=%b exp=1", bus.ext_gnt); end
        checks++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 32'h20 || bus.mem_wdata !== 32'h12345678) begin failures++; $display("FAIL ext_wr_port got=%b/%h/%h exp=1/00000020/12345678", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); end
        checks++; if (bus.lsu_stall !== 1'b0 || bus.mem_rvalid_in !== 1'b0) begin failures++; $display("FAIL ext_wr_side got=%b%b exp=00", bus.lsu_stall, bus.mem_rvalid_in); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_starvation();
        logic        exp_e;
        logic        exp_l;
        logic [31:0] exp_a;
        int          r;
        for (int c = 1; c <= 8; c++) begin
            clear_inputs();
            if (c <= 6) begin
                bus.lsu_rvalid_in = 1'b1;
                bus.lsu_raddr     = 32'h10;
                bus.ext_req       = 1'b1;
                bus.ext_we        = 1'b0;
                bus.ext_addr      = 32'h20;
            end
            @(negedge clk);
            if (c <= 6) begin
                exp_e = (c == 5);
                exp_a = (c == 5) ? 32'h20 : 32'h10;
                checks++; if (bus.ext_gnt !== exp_e) begin failures++; $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, bus.ext_gnt, exp_e); end
                checks++; if (bus.lsu_stall !== exp_e) begin failures++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, bus.lsu_stall, exp_e); end
                checks++; if (bus.mem_raddr !== exp_a) begin failures++; $display("FAIL starve_raddr c=%0d got=%h exp=%h", c, bus.mem_raddr, exp_a); end
            end
            if (c >= 3) begin
                r     = c - 2;
                exp_e = (r == 5);
                exp_l = (r != 5);
                checks++; if (bus.lsu_rvalid_out !== exp_l || bus.lsu_rdata !== (exp_l ? 32'hDEADBEEF : 32'h0)) begin failures++; $display("FAIL starve_lsu_resp c=%0d got=%b/%h exp=%b", c, bus.lsu_rvalid_out, bus.lsu_rdata, exp_l); end
                checks++; if (bus.ext_rvalid !== exp_e || bus.ext_rdata !== (exp_e ? 32'h12345678 : 32'h0)) begin failures++; $display("FAIL starve_ext_resp c=%0d got=%b/%h exp=%b", c, bus.ext_rvalid, bus.ext_rdata, exp_e); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        logic        odd;
        int          i;
        for (int c = 0; c <= 7; c++) begin
            clear_inputs();
            if (c < 6) begin
                if (c % 2 == 0) begin
                    bus.lsu_rvalid_in = 1'b1;
                    bus.lsu_raddr     = 32'h40 + 32'(4 * c);
                end else begin
                    bus.ext_req  = 1'b1;
                    bus.ext_addr = 32'h40 + 32'(4 * c);
                end
            end
            @(negedge clk);
            if (c < 6) begin
                odd = (c % 2 == 1);
                checks++; if (bus.mem_rvalid_in !== 1'b1 || bus.mem_raddr !== 32'h40 + 32'(4 * c) || bus.ext_gnt !== odd) begin failures++; $display("FAIL b2b_issue c=%0d got=%b/%h/%b exp=1/%h/%b", c, bus.mem_rvalid_in, bus.mem_raddr, bus.ext_gnt, 32'h40 + 32'(4 * c), odd); end
            end
            if (c >= 2) begin
                i     = c - 2;
                odd   = (i % 2 == 1);
                exp_d = 32'hA0000000 + 32'(i);
                checks++; if (bus.lsu_rvalid_out !== !odd || bus.lsu_rdata !== (odd ? 32'h0 : exp_d)) begin failures++; $display("FAIL b2b_lsu c=%0d got=%b/%h exp=%b/%h", c, bus.lsu_rvalid_out, bus.lsu_rdata, !odd, exp_d); end
                checks++; if (bus.ext_rvalid !== odd || bus.ext_rdata !== (odd ? exp_d : 32'h0)) begin failures++; $display("FAIL b2b_ext c=%0d got=%b/%h exp=%b/%h", c, bus.ext_rvalid, bus.ext_rdata, odd, exp_d); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        clear_inputs();
        bus.ext_req  = 1'b1;
        bus.ext_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.ext_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%b exp=1", bus.ext_gnt); end
        next_cycle();
        rst = 1'b1;
        bus.lsu_rvalid_in = 1'b1;
        bus.lsu_raddr     = 32'h10;
        bus.ext_addr      = 32'h20;
        @(negedge clk);
        checks++; if (bus.ext_gnt !== 1'b0 || bus.mem_raddr !== 32'h10 || bus.lsu_stall !== 1'b0) begin failures++; $display("FAIL rmid_prio got=%b/%h/%b exp=0/00000010/0", bus.ext_gnt, bus.mem_raddr, bus.lsu_stall); end
        checks++; if (bus.ext_rvalid !== 1'b0 || bus.lsu_rvalid_out !== 1'b0) begin failures++; $display("FAIL rmid_quiet1 got=%b%b exp=00", bus.ext_rvalid, bus.lsu_rvalid_out); end
        next_cycle();
        rst = 1'b0;
        bus.ext_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.ext_rvalid !== 1'b0 || bus.lsu_rvalid_out !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%b%b exp=00", bus.ext_rvalid, bus.lsu_rvalid_out); end
        checks++; if (dut.u_rd_ctr.count !== '0 || dut.u_wr_ctr.count !== '0) begin failures++; $display("FAIL rmid_ctr got=%0d/%0d exp=0/0", dut.u_rd_ctr.count, dut.u_wr_ctr.count); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.ext_rvalid !== 1'b0 || bus.lsu_rvalid_out !== 1'b0) begin failures++; $display("FAIL rmid_drop2 got=%b%b exp=00", bus.ext_rvalid, bus.lsu_rvalid_out); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b1 || bus.lsu_rdata !== 32'hDEADBEEF || bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_post got=%b/%h/%b exp=1/deadbeef/0", bus.lsu_rvalid_out, bus.lsu_rdata, bus.ext_rvalid); end
        next_cycle();
    endtask

    task automatic test_write_override();
        clear_inputs();
        bus.lsu_wen   = 1'b1;
        bus.lsu_waddr = 32'h80;
        bus.lsu_wdata = 32'h55AA55AA;
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b1;
        bus.ext_addr  = 32'h84;
        bus.ext_wdata = 32'h0BADF00D;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (bus.ext_gnt !== 1'b0 || bus.lsu_stall !== 1'b0 || bus.mem_waddr !== 32'h80 || bus.mem_wdata !== 32'h55AA55AA) begin failures++; $display("FAIL wov_lsu_wins c=%0d got=%b%b/%h/%h exp=00/00000080/55aa55aa", c, bus.ext_gnt, bus.lsu_stall, bus.mem_waddr, bus.mem_wdata); end
            next_cycle();
        end
        bus.lsu_rvalid_in = 1'b1;
        bus.lsu_raddr     = 32'h10;
        @(negedge clk);
        checks++; if (bus.mem_rvalid_in !== 1'b1 || bus.mem_raddr !== 32'h10) begin failures++; $display("FAIL wov_read_goes got=%b/%h exp=1/00000010", bus.mem_rvalid_in, bus.mem_raddr); end
        checks++; if (bus.ext_gnt !== 1'b1 || bus.lsu_stall !== 1'b1) begin failures++; $display("FAIL wov_override got=%b%b exp=11", bus.ext_gnt, bus.lsu_stall); end
        checks++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 32'h84 || bus.mem_wdata !== 32'h0BADF00D) begin failures++; $display("FAIL wov_ext_write got=%b/%h/%h exp=1/00000084/0badf00d", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); end
        next_cycle();
        clear_inputs();
        bus.lsu_wen   = 1'b1;
        bus.lsu_waddr = 32'h80;
        bus.lsu_wdata = 32'h55AA55AA;
        @(negedge clk);
        checks++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 32'h80 || bus.lsu_stall !== 1'b0 || bus.ext_gnt !== 1'b0) begin failures++; $display("FAIL wov_lsu_retry got=%b/%h/%b%b exp=1/00000080/00", bus.mem_wen, bus.mem_waddr, bus.lsu_stall, bus.ext_gnt); end
        next_cycle();
        clear_inputs();
        bus.lsu_rvalid_in = 1'b1;
        bus.lsu_raddr     = 32'h84;
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b1 || bus.lsu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wov_read_data got=%b/%h exp=1/deadbeef", bus.lsu_rvalid_out, bus.lsu_rdata); end
        next_cycle();
        bus.lsu_raddr = 32'h80;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b1 || bus.lsu_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL wov_ext_stored got=%b/%h exp=1/0badf00d", bus.lsu_rvalid_out, bus.lsu_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.lsu_rvalid_out !== 1'b1 || bus.lsu_rdata !== 32'h55AA55AA) begin failures++; $display("FAIL wov_lsu_stored got=%b/%h exp=1/55aa55aa", bus.lsu_rvalid_out, bus.lsu_rdata); end
        next_cycle();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) dccm[k] = 32'h0;
        dccm[8'h04] = 32'hDEADBEEF;
        for (int k = 0; k < 6; k++) dccm[8'h10 + k] = 32'hA0000000 + 32'(k);
        clear_inputs();
        test_reset();
        test_lsu_read();
        test_ext_write();
        test_starvation();
        test_back_to_back();
        test_reset_midflight();
        test_write_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
